// File: rtl/flag_bank_stack.sv
// flag_bank_stack
//   A bank of NUM_FLAGS status bits with per-bit masked write, set, clear and
//   toggle. It also has a save/restore stack of STACK_DEPTH entries. Control
//   flow pushes the live flags on entry to a subroutine or loop and pops them
//   back on exit.
//
// Ports
//   CLK       clock; every state update happens on the rising edge
//   RST_N     asynchronous active-low reset
//   op        00 hold, 01 masked write, 10 set, 11 clear
//   toggle    XOR mask onto the op result in the same cycle
//   mask      per-bit enable for op and toggle
//   din       data for masked write
//   push      save the current flags onto the stack
//   pop       restore the flags from the top of the stack
//   clr_err   clear the sticky error bits (a new error in the same cycle wins)
//   flagsout  live flags, registered
//   depth     number of stack entries in use
//   empty     depth == 0
//   full      depth == STACK_DEPTH
//   ovf_err   sticky: a push was made while the stack was full
//   unf_err   sticky: a pop was made while the stack was empty
module flag_bank_stack #(
  parameter int                 NUM_FLAGS   = 2,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [NUM_FLAGS-1:0] RESET_VAL = '0,
  localparam int                DW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [1:0]           op,
  input  logic                 toggle,
  input  logic [NUM_FLAGS-1:0] mask,
  input  logic [NUM_FLAGS-1:0] din,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  output logic [NUM_FLAGS-1:0] flagsout,
  output logic [DW-1:0]        depth,
  output logic                 empty,
  output logic                 full,
  output logic                 ovf_err,
  output logic                 unf_err
);

  localparam logic [DW-1:0] FULL_DEPTH = DW'(STACK_DEPTH);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
  logic [NUM_FLAGS-1:0] stack_d [STACK_DEPTH];
  logic [DW-1:0]        depth_q, depth_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;

  logic                 is_empty, is_full;
  logic [DW-1:0]        top_idx;
  logic [NUM_FLAGS-1:0] top_val;
  logic [NUM_FLAGS-1:0] op_val;

  assign is_empty = (depth_q == '0);
  assign is_full  = (depth_q == FULL_DEPTH);
  // This value is only used when the stack is not empty, so the wrap at
  // depth 0 does no harm.
  assign top_idx  = depth_q - 1'b1;

  // Read the top entry by comparing every slot with top_idx. The slot
  // number is never used as an array index, so the array can have any size.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i) == top_idx) top_val = stack_q[i];
    end
  end

  // Result of op and toggle on the live flags. Bits with mask=0 keep their value.
  always_comb begin
    op_val = flags_q;
    unique case (op)
      2'b01:   op_val = (flags_q & ~mask) | (din & mask);
      2'b10:   op_val = flags_q | mask;
      2'b11:   op_val = flags_q & ~mask;
      default: op_val = flags_q;
    endcase
    if (toggle) op_val = op_val ^ mask;
  end

  always_comb begin
    flags_d = op_val;
    depth_d = depth_q;
    stack_d = stack_q;
    ovf_d   = ovf_q & ~clr_err;
    unf_d   = unf_q & ~clr_err;

    if (pop && !is_empty) begin
      // A pop that takes effect has priority over op and toggle. If push is
      // also set, the top entry and the live flags swap places. This works
      // even when the stack is full.
      flags_d = top_val;
      if (push) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (DW'(i) == top_idx) stack_d[i] = flags_q;
        end
      end else begin
        depth_d = depth_q - 1'b1;
      end
    end else begin
      // Here op and toggle apply. A pop on an empty stack only sets the
      // error bit. A push still takes effect.
      if (pop) unf_d = 1'b1;
      if (push) begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < STACK_DEPTH; i++) begin
            if (DW'(i) == depth_q) stack_d[i] = flags_q;
          end
          depth_d = depth_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      flags_q <= RESET_VAL;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q <= flags_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign flagsout = flags_q;
  assign depth    = depth_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign ovf_err  = ovf_q;
  assign unf_err  = unf_q;

endmodule

// File: tb/tb_flag_bank_stack.sv
// tb_flag_bank_stack
//   Directed bench for flag_bank_stack with NUM_FLAGS=4, STACK_DEPTH=2 and
//   RESET_VAL=0. The expected values are worked out by hand from the
//   behaviour of the block.
module tb_flag_bank_stack;

  logic       CLK;
  logic       RST_N;
  logic [1:0] op;
  logic       toggle;
  logic [3:0] mask;
  logic [3:0] din;
  logic       push;
  logic       pop;
  logic       clr_err;
  logic [3:0] flagsout;
  logic [1:0] depth;
  logic       empty;
  logic       full;
  logic       ovf_err;
  logic       unf_err;

  int checks   = 0;
  int failures = 0;

  flag_bank_stack #(
    .NUM_FLAGS  (4),
    .STACK_DEPTH(2),
    .RESET_VAL  (4'b0000)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .op      (op),
    .toggle  (toggle),
    .mask    (mask),
    .din     (din),
    .push    (push),
    .pop     (pop),
    .clr_err (clr_err),
    .flagsout(flagsout),
    .depth   (depth),
    .empty   (empty),
    .full    (full),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the clock edge pass, and return 1 time
  // unit after the edge with the inputs back at idle.
  task automatic cyc(input logic [1:0] t_op, input logic t_tog, input logic [3:0] t_mask,
                     input logic [3:0] t_din, input logic t_push, input logic t_pop,
                     input logic t_clr);
    op = t_op; toggle = t_tog; mask = t_mask; din = t_din;
    push = t_push; pop = t_pop; clr_err = t_clr;
    @(posedge CLK);
    #1;
    op = 2'b00; toggle = 1'b0; mask = 4'b0000; din = 4'b0000;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    op = 2'b00; toggle = 1'b0; mask = 4'b0000; din = 4'b0000;
    push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_flags", 8'(flagsout), 8'h0);
    check("rst_depth", 8'(depth), 8'd0);
    check("rst_empty", 8'(empty), 8'd1);
    check("rst_full",  8'(full),  8'd0);
    check("rst_ovf",   8'(ovf_err), 8'd0);
    check("rst_unf",   8'(unf_err), 8'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // masked operations
    cyc(2'b01, 1'b0, 4'b0110, 4'b1111, 1'b0, 1'b0, 1'b0);
    check("op_write", 8'(flagsout), 8'b0110);
    cyc(2'b10, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("op_set", 8'(flagsout), 8'b1110);
    cyc(2'b11, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("op_clear", 8'(flagsout), 8'b1100);
    cyc(2'b00, 1'b1, 4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("op_toggle", 8'(flagsout), 8'b1001);
    cyc(2'b00, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("op_hold", 8'(flagsout), 8'b1001);

    // push together with an op, then pop
    cyc(2'b10, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("push_flags", 8'(flagsout), 8'b1111);
    check("push_depth", 8'(depth), 8'd1);
    check("push_empty", 8'(empty), 8'd0);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("pop_flags", 8'(flagsout), 8'b1001);
    check("pop_depth", 8'(depth), 8'd0);
    check("pop_empty", 8'(empty), 8'd1);

    // overflow
    cyc(2'b01, 1'b0, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 1'b0);
    check("ovf_push1_flags", 8'(flagsout), 8'b0010);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("ovf_full", 8'(full), 8'd1);
    check("ovf_depth2", 8'(depth), 8'd2);
    check("ovf_err_pre", 8'(ovf_err), 8'd0);
    cyc(2'b01, 1'b0, 4'b1111, 4'b1100, 1'b1, 1'b0, 1'b0);
    check("ovf_err_set", 8'(ovf_err), 8'd1);
    check("ovf_depth_sat", 8'(depth), 8'd2);
    check("ovf_op_applies", 8'(flagsout), 8'b1100);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("ovf_pop1", 8'(flagsout), 8'b0010);
    check("ovf_pop1_depth", 8'(depth), 8'd1);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("ovf_pop2", 8'(flagsout), 8'b0001);
    check("ovf_still_sticky", 8'(ovf_err), 8'd1);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", 8'(ovf_err), 8'd0);
    check("ovf_unf_clean", 8'(unf_err), 8'd0);

    // underflow
    cyc(2'b01, 1'b0, 4'b1111, 4'b0011, 1'b0, 1'b0, 1'b0);
    cyc(2'b10, 1'b0, 4'b1000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("unf_flags", 8'(flagsout), 8'b1011);
    check("unf_err_set", 8'(unf_err), 8'd1);
    check("unf_depth", 8'(depth), 8'd0);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    check("unf_set_wins", 8'(unf_err), 8'd1);
    check("unf_hold_flags", 8'(flagsout), 8'b1011);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("unf_clr", 8'(unf_err), 8'd0);

    // swap
    cyc(2'b01, 1'b0, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0);
    cyc(2'b01, 1'b0, 4'b1111, 4'b1010, 1'b1, 1'b0, 1'b0);
    check("swap_pre_flags", 8'(flagsout), 8'b1010);
    cyc(2'b10, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b1, 1'b0);
    check("swap_flags", 8'(flagsout), 8'b0101);
    check("swap_depth", 8'(depth), 8'd1);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("swap_pop", 8'(flagsout), 8'b1010);
    check("swap_pop_depth", 8'(depth), 8'd0);

    // push and pop together on an empty stack: the pop fails, the push proceeds
    cyc(2'b11, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0);
    check("pp_empty_unf", 8'(unf_err), 8'd1);
    check("pp_empty_depth", 8'(depth), 8'd1);
    check("pp_empty_flags", 8'(flagsout), 8'b1000);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    check("pp_empty_pop", 8'(flagsout), 8'b1010);
    check("pp_empty_unf_clr", 8'(unf_err), 8'd0);

    // asynchronous reset in the middle of a sequence
    cyc(2'b01, 1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("ar_pre_depth", 8'(depth), 8'd2);
    check("ar_pre_ovf", 8'(ovf_err), 8'd1);
    check("ar_pre_flags", 8'(flagsout), 8'b1111);
    #2;
    RST_N = 1'b0;
    #1;
    check("ar_flags", 8'(flagsout), 8'h0);
    check("ar_depth", 8'(depth), 8'd0);
    check("ar_empty", 8'(empty), 8'd1);
    check("ar_full", 8'(full), 8'd0);
    check("ar_ovf", 8'(ovf_err), 8'd0);
    check("ar_unf", 8'(unf_err), 8'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(2'b00, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("ar_pop_unf", 8'(unf_err), 8'd1);
    check("ar_pop_depth", 8'(depth), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // A stall in the bench should never happen. If one does, report it and stop.
  initial begin
    #20000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/flag_bank_stack.md
Name: flag_bank_stack

Overview:
Parametrised successor to the processor's flip/flag single-bit registers. Holds NUM_FLAGS status bits with per-bit masked write, set, clear and toggle operations. Adds a save/restore stack of depth STACK_DEPTH, so control flow (subroutine/loop entry) can push the live flags and later pop them back. Sits beside the register file; the decoder drives op/mask, and ALU and branch logic consume flagsout.

Parameters:
NUM_FLAGS, 2, number of flag bits (≥1)
STACK_DEPTH, 4, number of save/restore entries (≥1)
RESET_VAL, 0, NUM_FLAGS-bit reset value of the live flags

Ports:
CLK  input  1  clock, all state updates on posedge
RST_N  input  1  asynchronous active-low reset
op  input  2  00 hold, 01 masked write, 10 set, 11 clear
toggle  input  1  XOR masked bits (see priority)
mask  input  NUM_FLAGS  per-bit enable for op/toggle
din  input  NUM_FLAGS  data for masked write
push  input  1  save current flags onto stack
pop  input  1  restore flags from stack top
clr_err  input  1  clear sticky error bits
flagsout  output  NUM_FLAGS  live flags, registered
depth  output  $clog2(STACK_DEPTH+1)  entries in use
empty  output  1  depth==0
full  output  1  depth==STACK_DEPTH
ovf_err  output  1  sticky: push while full
unf_err  output  1  sticky: pop while empty

Behaviour:
- Reset (async, RST_N=0): flagsout=RESET_VAL, depth=0, empty=1, full=0, ovf_err=0, unf_err=0. Stack contents are don't-care and are not readable until pushed.
- All outputs are registered. An operation applied at edge N is visible after edge N. Zero-cycle combinational paths from inputs to outputs are forbidden.
- Live-flag update when pop is not effective:
  - op=01: F=(F&~mask)|(din&mask).
  - op=10: F=F|mask.
  - op=11: F=F&~mask.
  - op=00: F unchanged.
  - If toggle=1, XOR mask onto the op result in the same cycle. With op=00, this toggles the masked bits. Bits with mask=0 never change.
- Effective pop (pop=1, depth>0): F=stack[top], depth-1. op and toggle are ignored that cycle.
- Effective push (push=1, depth<STACK_DEPTH): stack[depth]=F as it was before this edge, depth+1. op/toggle still apply to the live F.
- push & pop in the same cycle with depth>0: swap. F=stack[top] and stack[top]=old F. depth unchanged. op/toggle ignored. This holds even when full.
- push & pop in the same cycle with depth==0: the pop is a failed pop (unf_err=1). The push proceeds normally and op/toggle apply.
- Push while full (no pop): entry is dropped, depth stays STACK_DEPTH, ovf_err=1. op/toggle apply.
- Pop while empty (no push): F updated by op/toggle only, depth stays 0, unf_err=1.
- Error bits: sticky until clr_err. If an error condition and clr_err coincide, the error bit sets (set wins).
- depth never wraps: it is saturating at 0 and STACK_DEPTH by the rules above. empty/full are derived combinationally from registered depth.
- RST_N asserted mid-sequence: immediate return to reset values regardless of CLK. No partial push/pop completes.

Test Plan:
All scenarios use NUM_FLAGS=4, STACK_DEPTH=2, RESET_VAL=4'b0000.
- Reset/masked ops: release RST_N; op=01 mask=0110 din=1111 → flagsout=0110. Then op=10 mask=1000 → 1110. Then op=11 mask=0010 → 1100. Then op=00 toggle=1 mask=0101 → 1001.
- Push/pop with concurrent op: F=1001; push with op=10 mask=0110 → F=1111, depth=1, stack[0]=1001. Then pop → F=1001, depth=0, empty=1.
- Overflow: push 0001, push 0010 → full=1, depth=2. Third push → ovf_err=1, depth=2. Pop twice → F=0010 then F=0001. clr_err → ovf_err=0.
- Underflow: depth=0, F=0011, pop with op=10 mask=1000 → F=1011, unf_err=1, depth=0. clr_err together with another empty pop → unf_err stays 1.
- Swap: stack[0]=0101, F=1010, push&pop → F=0101, stack[0]=1010, depth=1. Then pop → F=1010.
- Async reset mid-operation: assert RST_N low between edges with depth=2, F=1111 → immediately flagsout=0000, depth=0, empty=1, errors=0. The next pop after release sets unf_err.
